// File: rtl/pad_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module      : pad_ctrl_pkg
// Description : Shared definitions for the user-project pad controller:
//               register offsets, ID constant, register reset values and
//               small helpers for pad masks and byte-lane expansion.
// Revision    : 1.0 - initial release
// ============================================================================
package pad_ctrl_pkg;

    // Byte offsets within the 256-byte window (lo word = pads 0..31).
    localparam logic [7:0] c_OFF_OUT_LO  = 8'h00;
    localparam logic [7:0] c_OFF_OUT_HI  = 8'h04;
    localparam logic [7:0] c_OFF_OEB_LO  = 8'h08;
    localparam logic [7:0] c_OFF_OEB_HI  = 8'h0C;
    localparam logic [7:0] c_OFF_SEL_LO  = 8'h10;
    localparam logic [7:0] c_OFF_SEL_HI  = 8'h14;
    localparam logic [7:0] c_OFF_IN_LO   = 8'h18;
    localparam logic [7:0] c_OFF_IN_HI   = 8'h1C;
    localparam logic [7:0] c_OFF_IEN_LO  = 8'h20;
    localparam logic [7:0] c_OFF_IEN_HI  = 8'h24;
    localparam logic [7:0] c_OFF_STAT_LO = 8'h28;
    localparam logic [7:0] c_OFF_STAT_HI = 8'h2C;
    localparam logic [7:0] c_OFF_ID      = 8'h30;

    // The pad count is OR-ed into the low byte of this value.
    localparam logic [31:0] c_ID_BASE = 32'h5241_5000;

    // Reset values before masking to the implemented pad count.
    localparam logic [63:0] c_RST_OUT      = 64'h0;
    localparam logic [63:0] c_RST_OEB      = {64{1'b1}};
    localparam logic [63:0] c_RST_SEL      = {64{1'b1}};
    localparam logic [63:0] c_RST_IRQ_EN   = 64'h0;
    localparam logic [63:0] c_RST_IRQ_STAT = 64'h0;

    // One bit set for every implemented pad.
    function automatic logic [63:0] pad_mask(input int unsigned pads);
        logic [63:0] m;
        m = '0;
        for (int i = 0; i < 64; i++) begin
            if (i < pads) m[i] = 1'b1;
        end
        return m;
    endfunction

    // Expand the 4-bit byte select into a 32-bit write mask.
    function automatic logic [31:0] lane_mask(input logic [3:0] sel);
        logic [31:0] m;
        m = '0;
        for (int k = 0; k < 4; k++) begin
            if (sel[k]) m[8*k +: 8] = 8'hFF;
        end
        return m;
    endfunction

endpackage
`default_nettype wire

// File: rtl/pad_sync.sv
`default_nettype none
// ============================================================================
// Module      : pad_sync
// Description : Single-pad input synchroniser with edge detection.
//               Ports: clk, rst (sync, active-high), d (raw pad input),
//               edge_en (gates edge reporting), q (synchronised value),
//               edge_det (q differs from its previous sample).
// Revision    : 1.0 - initial release
// ============================================================================
module pad_sync
    import pad_ctrl_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    input  logic edge_en,
    output logic q,
    output logic edge_det
);

    logic [DEPTH-1:0] r_chain;
    logic             r_prev;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_chain <= '0;
            r_prev  <= 1'b0;
        end else begin
            r_chain <= {r_chain[DEPTH-2:0], d};
            r_prev  <= r_chain[DEPTH-1];
        end
    end

    assign q        = r_chain[DEPTH-1];
    assign edge_det = edge_en & (r_chain[DEPTH-1] ^ r_prev);

endmodule
`default_nettype wire

// File: rtl/user_proj_pad_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : user_proj_pad_ctrl
// Description : Wishbone-controlled pad multiplexer with input synchronisers
//               and per-pad edge interrupts.
//               Ports: wb_clk_i/wb_rst_i (clock, sync active-high reset),
//               wbs_* (Wishbone slave), core_out/core_oeb/core_in (core side),
//               io_in/io_out/io_oeb (pad side), irq_o (level interrupt).
// Revision    : 1.0 - initial release
// ============================================================================
module user_proj_pad_ctrl
    import pad_ctrl_pkg::*;
#(
    parameter int          PADS        = 38,
    parameter logic [31:0] BASE_ADDR   = 32'h3000_0000,
    parameter int          SYNC_STAGES = 2
) (
    input  logic            wb_clk_i,
    input  logic            wb_rst_i,
    input  logic            wbs_cyc_i,
    input  logic            wbs_stb_i,
    input  logic            wbs_we_i,
    input  logic [3:0]      wbs_sel_i,
    input  logic [31:0]     wbs_adr_i,
    input  logic [31:0]     wbs_dat_i,
    output logic            wbs_ack_o,
    output logic [31:0]     wbs_dat_o,
    input  logic [PADS-1:0] core_out,
    input  logic [PADS-1:0] core_oeb,
    output logic [PADS-1:0] core_in,
    input  logic [PADS-1:0] io_in,
    output logic [PADS-1:0] io_out,
    output logic [PADS-1:0] io_oeb,
    output logic            irq_o
);

    localparam logic [63:0] c_MASK = pad_mask(PADS);
    localparam logic [31:0] c_ID   = c_ID_BASE | 32'(PADS);

    logic [63:0] r_out, r_oeb, r_sel, r_irq_en, r_irq_stat;
    logic        r_ack, r_irq, r_edge_en;
    logic [31:0] r_dat;

    logic        w_valid, w_hit, w_wr;
    logic [31:0] w_lane, w_rdata;
    logic [63:0] w_sync, w_edge, w_clr;
    logic [63:0] w_out_nxt, w_oeb_nxt, w_sel_nxt, w_ien_nxt, w_stat_nxt;

    // ---------------------------------------------------------------- pads
    for (genvar n = 0; n < PADS; n++) begin : g_pad
        pad_sync #(.DEPTH(SYNC_STAGES)) u_sync (
            .clk      (wb_clk_i),
            .rst      (wb_rst_i),
            .d        (io_in[n]),
            .edge_en  (r_edge_en),
            .q        (w_sync[n]),
            .edge_det (w_edge[n])
        );
        assign core_in[n] = w_sync[n];
        assign io_out[n]  = r_sel[n] ? core_out[n] : r_out[n];
        assign io_oeb[n]  = r_sel[n] ? core_oeb[n] : r_oeb[n];
    end

    for (genvar n = PADS; n < 64; n++) begin : g_tie
        assign w_sync[n] = 1'b0;
        assign w_edge[n] = 1'b0;
    end

    // ------------------------------------------------------------- decode
    // Holding ack for a cycle blocks re-triggering on the same strobe.
    assign w_valid = wbs_cyc_i & wbs_stb_i & ~r_ack;
    assign w_hit   = (wbs_adr_i[31:8] == BASE_ADDR[31:8]);
    assign w_wr    = w_valid & w_hit & wbs_we_i;
    assign w_lane  = lane_mask(wbs_sel_i);

    always_comb begin
        w_out_nxt = r_out;
        w_oeb_nxt = r_oeb;
        w_sel_nxt = r_sel;
        w_ien_nxt = r_irq_en;
        w_clr     = '0;
        if (w_wr) begin
            case (wbs_adr_i[7:0])
                c_OFF_OUT_LO:  w_out_nxt[31:0]  = (r_out[31:0]     & ~w_lane) | (wbs_dat_i & w_lane);
                c_OFF_OUT_HI:  w_out_nxt[63:32] = (r_out[63:32]    & ~w_lane) | (wbs_dat_i & w_lane);
                c_OFF_OEB_LO:  w_oeb_nxt[31:0]  = (r_oeb[31:0]     & ~w_lane) | (wbs_dat_i & w_lane);
                c_OFF_OEB_HI:  w_oeb_nxt[63:32] = (r_oeb[63:32]    & ~w_lane) | (wbs_dat_i & w_lane);
                c_OFF_SEL_LO:  w_sel_nxt[31:0]  = (r_sel[31:0]     & ~w_lane) | (wbs_dat_i & w_lane);
                c_OFF_SEL_HI:  w_sel_nxt[63:32] = (r_sel[63:32]    & ~w_lane) | (wbs_dat_i & w_lane);
                c_OFF_IEN_LO:  w_ien_nxt[31:0]  = (r_irq_en[31:0]  & ~w_lane) | (wbs_dat_i & w_lane);
                c_OFF_IEN_HI:  w_ien_nxt[63:32] = (r_irq_en[63:32] & ~w_lane) | (wbs_dat_i & w_lane);
                c_OFF_STAT_LO: w_clr[31:0]      = wbs_dat_i & w_lane;
                c_OFF_STAT_HI: w_clr[63:32]     = wbs_dat_i & w_lane;
                default: ;
            endcase
        end
        w_out_nxt  = w_out_nxt & c_MASK;
        w_oeb_nxt  = w_oeb_nxt & c_MASK;
        w_sel_nxt  = w_sel_nxt & c_MASK;
        w_ien_nxt  = w_ien_nxt & c_MASK;
        // A new edge is OR-ed in after the clear so it survives a W1C.
        w_stat_nxt = ((r_irq_stat & ~w_clr) | w_edge) & c_MASK;
    end

    always_comb begin
        w_rdata = '0;
        if (w_hit) begin
            case (wbs_adr_i[7:0])
                c_OFF_OUT_LO:  w_rdata = r_out[31:0];
                c_OFF_OUT_HI:  w_rdata = r_out[63:32];
                c_OFF_OEB_LO:  w_rdata = r_oeb[31:0];
                c_OFF_OEB_HI:  w_rdata = r_oeb[63:32];
                c_OFF_SEL_LO:  w_rdata = r_sel[31:0];
                c_OFF_SEL_HI:  w_rdata = r_sel[63:32];
                c_OFF_IN_LO:   w_rdata = w_sync[31:0];
                c_OFF_IN_HI:   w_rdata = w_sync[63:32];
                c_OFF_IEN_LO:  w_rdata = r_irq_en[31:0];
                c_OFF_IEN_HI:  w_rdata = r_irq_en[63:32];
                c_OFF_STAT_LO: w_rdata = r_irq_stat[31:0];
                c_OFF_STAT_HI: w_rdata = r_irq_stat[63:32];
                c_OFF_ID:      w_rdata = c_ID;
                default:       w_rdata = '0;
            endcase
        end
    end

    // ----------------------------------------------------------- registers
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            r_out      <= c_RST_OUT      & c_MASK;
            r_oeb      <= c_RST_OEB      & c_MASK;
            r_sel      <= c_RST_SEL      & c_MASK;
            r_irq_en   <= c_RST_IRQ_EN   & c_MASK;
            r_irq_stat <= c_RST_IRQ_STAT & c_MASK;
            r_ack      <= 1'b0;
            r_dat      <= '0;
            r_irq      <= 1'b0;
            r_edge_en  <= 1'b0;
        end else begin
            r_out      <= w_out_nxt;
            r_oeb      <= w_oeb_nxt;
            r_sel      <= w_sel_nxt;
            r_irq_en   <= w_ien_nxt;
            r_irq_stat <= w_stat_nxt;
            r_ack      <= w_valid;
            r_dat      <= w_valid ? w_rdata : 32'h0;
            r_irq      <= |(r_irq_stat & r_irq_en);
            // Stays low for the first cycle out of reset.
            r_edge_en  <= 1'b1;
        end
    end

    assign wbs_ack_o = r_ack;
    assign wbs_dat_o = r_dat;
    assign irq_o     = r_irq;

endmodule
`default_nettype wire

// File: tb/tb_user_proj_pad_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_user_proj_pad_ctrl
// Description : Self-checking bench for user_proj_pad_ctrl: directed checks
//               of reset, pad mux, byte lanes, interrupts and unmapped
//               accesses, then random register traffic against a model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_user_proj_pad_ctrl;

    localparam int          PADS = 38;
    localparam int          SYNC = 2;
    localparam logic [31:0] BASE = 32'h3000_0000;
    localparam logic [63:0] PMSK = (64'd1 << PADS) - 64'd1;

    logic            clk = 1'b0;
    logic            rst;
    logic            cyc, stb, we;
    logic [3:0]      sel;
    logic [31:0]     adr, dat_w;
    logic            ack;
    logic [31:0]     dat_r;
    logic [PADS-1:0] core_out, core_oeb, core_in, io_in, io_out, io_oeb;
    logic            irq;

    user_proj_pad_ctrl #(.PADS(PADS), .BASE_ADDR(BASE), .SYNC_STAGES(SYNC)) dut (
        .wb_clk_i (clk),      .wb_rst_i (rst),
        .wbs_cyc_i(cyc),      .wbs_stb_i(stb),      .wbs_we_i (we),
        .wbs_sel_i(sel),      .wbs_adr_i(adr),      .wbs_dat_i(dat_w),
        .wbs_ack_o(ack),      .wbs_dat_o(dat_r),
        .core_out (core_out), .core_oeb (core_oeb), .core_in  (core_in),
        .io_in    (io_in),    .io_out   (io_out),   .io_oeb   (io_oeb),
        .irq_o    (irq)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    // Reference model state, 64 bits per register (bits >= PADS stay 0).
    logic [63:0] m_out, m_oeb, m_sel, m_en, m_stat;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        assert (got === exp) else begin
            n_err++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // One Wishbone access; called just after a falling edge.
    task automatic wb(input logic w, input logic [31:0] a, input logic [31:0] d,
                      input logic [3:0] s, output logic [31:0] rd);
        cyc = 1'b1; stb = 1'b1; we = w; adr = a; dat_w = d; sel = s;
        @(posedge clk); #1;
        chk("ack_rise", {63'h0, ack}, 64'h1);
        rd = dat_r;
        @(posedge clk); #1;
        chk("ack_one_cycle", {63'h0, ack}, 64'h0);
        chk("dat_idle_zero", {32'h0, dat_r}, 64'h0);
        cyc = 1'b0; stb = 1'b0; we = 1'b0;
        @(negedge clk);
    endtask

    task automatic wr(input logic [7:0] off, input logic [31:0] d, input logic [3:0] s);
        logic [31:0] junk;
        wb(1'b1, BASE | {24'h0, off}, d, s, junk);
    endtask

    task automatic rdchk(input string tag, input logic [31:0] a, input logic [31:0] exp);
        logic [31:0] r;
        wb(1'b0, a, 32'h0, 4'hF, r);
        chk(tag, {32'h0, r}, {32'h0, exp});
    endtask

    function automatic logic [31:0] lanes(input logic [3:0] s);
        logic [31:0] m;
        m = '0;
        for (int k = 0; k < 4; k++) if (s[k]) m[8*k +: 8] = 8'hFF;
        return m;
    endfunction

    function automatic logic [63:0] merge(input logic [63:0] old, input bit hi,
                                          input logic [31:0] d, input logic [3:0] s);
        logic [63:0] n;
        logic [31:0] word;
        word = hi ? old[63:32] : old[31:0];
        word = (word & ~lanes(s)) | (d & lanes(s));
        n = old;
        if (hi) n[63:32] = word; else n[31:0] = word;
        return n & PMSK;
    endfunction

    function automatic logic [31:0] m_read(input logic [7:0] off, input logic [63:0] inv);
        case (off)
            8'h00: return m_out[31:0];   8'h04: return m_out[63:32];
            8'h08: return m_oeb[31:0];   8'h0C: return m_oeb[63:32];
            8'h10: return m_sel[31:0];   8'h14: return m_sel[63:32];
            8'h18: return inv[31:0];     8'h1C: return inv[63:32];
            8'h20: return m_en[31:0];    8'h24: return m_en[63:32];
            8'h28: return m_stat[31:0];  8'h2C: return m_stat[63:32];
            8'h30: return 32'h5241_5000 | PADS;
            default: return 32'h0;
        endcase
    endfunction

    task automatic m_write(input logic [7:0] off, input logic [31:0] d, input logic [3:0] s);
        logic [63:0] clr;
        case (off)
            8'h00, 8'h04: m_out = merge(m_out, off[2], d, s);
            8'h08, 8'h0C: m_oeb = merge(m_oeb, off[2], d, s);
            8'h10, 8'h14: m_sel = merge(m_sel, off[2], d, s);
            8'h20, 8'h24: m_en  = merge(m_en,  off[2], d, s);
            8'h28, 8'h2C: begin
                clr = merge(64'h0, off[2], d, s);
                m_stat = m_stat & ~clr;
            end
            default: ;
        endcase
    endtask

    initial begin
        logic [63:0]     tmp, inv, exp_o, exp_e;
        logic [PADS-1:0] core_pat;
        logic [31:0]     r;
        logic [7:0]      off;
        logic [3:0]      s;
        logic            w;

        rst = 1'b1; cyc = 1'b0; stb = 1'b0; we = 1'b0; sel = 4'h0;
        adr = '0; dat_w = '0; io_in = '0;
        core_out = 38'h2B_1357_9BDF;
        core_oeb = 38'h15_A5C3_3C5A;
        repeat (3) @(negedge clk);
        rst = 1'b0;

        // ---- reset state
        chk("rst_ack",     {63'h0, ack}, 64'h0);
        chk("rst_dat",     {32'h0, dat_r}, 64'h0);
        chk("rst_irq",     {63'h0, irq}, 64'h0);
        chk("rst_io_out",  64'(io_out), 64'h2B_1357_9BDF);
        chk("rst_io_oeb",  64'(io_oeb), 64'h15_A5C3_3C5A);
        chk("rst_core_in", 64'(core_in), 64'h0);
        rdchk("rst_oeb_lo", BASE | 32'h08, 32'hFFFF_FFFF);
        rdchk("rst_oeb_hi", BASE | 32'h0C, 32'h0000_003F);
        rdchk("rst_sel_hi", BASE | 32'h14, 32'h0000_003F);
        rdchk("rst_out_lo", BASE | 32'h00, 32'h0);
        rdchk("rst_id",     BASE | 32'h30, 32'h5241_5026);

        // ---- pad mux
        wr(8'h10, 32'h0, 4'hF);
        wr(8'h00, 32'hA5A5_A5A5, 4'hF);
        wr(8'h08, 32'h0, 4'hF);
        chk("mux_out_lo", 64'(io_out[31:0]), 64'hA5A5_A5A5);
        chk("mux_oeb_lo", 64'(io_oeb[31:0]), 64'h0);
        chk("mux_out_hi_core", 64'(io_out[37:32]), 64'h2B);
        wr(8'h10, 32'hFFFF_FFFF, 4'hF);
        core_out = 38'h0F_0F0F_1234;
        #1;
        chk("mux_follow_core", 64'(io_out[31:0]), 64'h0F0F_1234);
        chk("mux_oeb_core",    64'(io_oeb[31:0]), 64'hA5C3_3C5A);

        // ---- byte lanes and unimplemented bits
        wr(8'h00, 32'h0, 4'hF);
        wr(8'h00, 32'h1234_5678, 4'b0010);
        rdchk("lane_out_lo", BASE | 32'h00, 32'h0000_5600);
        wr(8'h04, 32'hFFFF_FFFF, 4'hF);
        rdchk("hi_masked", BASE | 32'h04, 32'h0000_003F);
        wr(8'h30, 32'h0, 4'hF);
        rdchk("id_ro", BASE | 32'h30, 32'h5241_5026);
        wr(8'h18, 32'hFFFF_FFFF, 4'hF);
        rdchk("in_ro", BASE | 32'h18, 32'h0);

        // ---- interrupt on rising edge of pad 0
        wr(8'h20, 32'h1, 4'hF);
        io_in[0] = 1'b1;
        repeat (SYNC + 1) @(posedge clk);
        #1 chk("irq_not_yet", {63'h0, irq}, 64'h0);
        @(posedge clk);
        #1 chk("irq_raised", {63'h0, irq}, 64'h1);
        @(negedge clk);
        rdchk("stat_set", BASE | 32'h28, 32'h1);
        chk("core_in_sync", 64'(core_in), 64'h1);
        wr(8'h28, 32'h0, 4'hF);
        rdchk("stat_w0_keep", BASE | 32'h28, 32'h1);
        wr(8'h28, 32'h1, 4'hF);
        chk("irq_cleared", {63'h0, irq}, 64'h0);
        rdchk("stat_clear", BASE | 32'h28, 32'h0);

        // ---- W1C colliding with a new (falling) edge: set wins
        io_in[0] = 1'b0;
        repeat (SYNC) @(posedge clk);
        @(negedge clk);
        wr(8'h28, 32'h1, 4'hF);
        rdchk("collide_stat", BASE | 32'h28, 32'h1);
        chk("collide_irq", {63'h0, irq}, 64'h1);
        wr(8'h28, 32'h1, 4'hF);

        // ---- unmapped accesses
        rdchk("unmap_off", BASE | 32'h40, 32'h0);
        rdchk("unmap_base", 32'h3000_0100, 32'h0);
        wb(1'b1, 32'h3000_0100, 32'hFFFF_FFFF, 4'hF, r);
        wb(1'b1, BASE | 32'h40, 32'hFFFF_FFFF, 4'hF, r);
        rdchk("unmap_no_write", BASE | 32'h00, 32'h0000_5600);
        rdchk("unmap_sel_keep", BASE | 32'h10, 32'hFFFF_FFFF);

        // ---- reset during an access aborts it
        cyc = 1'b1; stb = 1'b1; we = 1'b1; adr = BASE; dat_w = 32'hFFFF_FFFF; sel = 4'hF;
        rst = 1'b1;
        @(posedge clk); #1;
        chk("rst_abort_ack", {63'h0, ack}, 64'h0);
        cyc = 1'b0; stb = 1'b0; we = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        rdchk("rst_abort_nowrite", BASE | 32'h00, 32'h0);
        rdchk("rst_oeb_again", BASE | 32'h08, 32'hFFFF_FFFF);

        // ---- random traffic against the model
        m_out = 64'h0; m_oeb = PMSK; m_sel = PMSK; m_en = 64'h0; m_stat = 64'h0;
        tmp   = {$urandom, $urandom};
        io_in = tmp[PADS-1:0];
        inv   = 64'(io_in);
        repeat (SYNC + 3) @(negedge clk);
        wr(8'h28, 32'hFFFF_FFFF, 4'hF);
        wr(8'h2C, 32'hFFFF_FFFF, 4'hF);
        rdchk("in_lo", BASE | 32'h18, inv[31:0]);
        rdchk("in_hi", BASE | 32'h1C, inv[63:32]);
        for (int i = 0; i < 60; i++) begin
            off = 8'($urandom_range(0, 13)) << 2;
            w   = 1'($urandom_range(0, 1));
            s   = 4'($urandom);
            tmp = {$urandom, $urandom};
            if (w) begin
                wr(off, tmp[31:0], s);
                m_write(off, tmp[31:0], s);
            end else begin
                rdchk("rand_read", BASE | {24'h0, off}, m_read(off, inv));
            end
            core_pat = tmp[63:26];
            core_out = core_pat;
            tmp      = {$urandom, $urandom};
            core_oeb = tmp[PADS-1:0];
            #1;
            exp_o = ((m_sel & 64'(core_out)) | (~m_sel & m_out)) & PMSK;
            exp_e = ((m_sel & 64'(core_oeb)) | (~m_sel & m_oeb)) & PMSK;
            chk("rand_io_out", 64'(io_out), exp_o);
            chk("rand_io_oeb", 64'(io_oeb), exp_e);
            chk("rand_irq", {63'h0, irq}, {63'h0, |(m_stat & m_en)});
            @(negedge clk);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/user_proj_pad_ctrl.md
USER_PROJ_PAD_CTRL -- requirements
Module: user_proj_pad_ctrl

Interface
REQ-001 SHALL have parameter PADS, default 38, number of user pads (1..64).
REQ-002 SHALL have parameter BASE_ADDR, default 32'h3000_0000, Wishbone base; decode on adr[31:8].
REQ-003 SHALL have parameter SYNC_STAGES, default 2, input synchroniser depth (2..3).
REQ-004 SHALL have one clock and a synchronous, active-high reset: wb_clk_i in 1 (the only clock); wb_rst_i in 1 (reset).
REQ-005 SHALL have Wishbone slave ports: wbs_cyc_i in 1; wbs_stb_i in 1; wbs_we_i in 1; wbs_sel_i in 4; wbs_adr_i in 32; wbs_dat_i in 32; wbs_ack_o out 1; wbs_dat_o out 32.
REQ-006 SHALL have core ports: core_out in PADS (core-driven pad value); core_oeb in PADS (core output-enable, active-low); core_in out PADS (synchronised pad inputs).
REQ-007 SHALL have pad ports: io_in in PADS; io_out out PADS; io_oeb out PADS (active-low enable).
REQ-008 SHALL have irq_o out 1, level interrupt.

Function
REQ-009 SHALL map registers as lo/hi word pairs, bit n = pad n, lo = pads 0..31, hi = pads 32..63: OUT 0x00/0x04 RW; OEB 0x08/0x0C RW; SEL 0x10/0x14 RW (1 = core drives pad); IN 0x18/0x1C RO; IRQ_EN 0x20/0x24 RW; IRQ_STAT 0x28/0x2C W1C; ID 0x30 RO 32'h5241_5000 | PADS.
REQ-010 SHALL, per pad n: io_out[n] = SEL[n] ? core_out[n] : OUT[n], and io_oeb[n] = SEL[n] ? core_oeb[n] : OEB[n], combinationally.
REQ-011 SHALL pass io_in through a SYNC_STAGES flop chain; core_in and IN register reads SHALL present the last stage.
REQ-012 SHALL treat an access as valid when cyc && stb && !wbs_ack_o; wbs_ack_o SHALL assert exactly one cycle after a valid access and stay high exactly one cycle.
REQ-013 SHALL register wbs_dat_o in the same edge as ack; it SHALL read 0 when ack is low.
REQ-014 SHALL apply writes on the acking edge per byte lane, gated by wbs_sel_i[k].
REQ-015 SHALL ack, with read data 0 and no side effect, accesses that are outside BASE_ADDR[31:8] or hit unmapped offsets, so the bus never stalls.
REQ-016 SHALL hold bits at index >= PADS at 0 in every register; writes to them SHALL be ignored.
REQ-017 SHALL write to RO registers without side effect.
REQ-018 SHALL set IRQ_STAT[n] on any edge of the synchronised input; an edge is last stage != previous-sample flop.
REQ-019 SHALL clear IRQ_STAT[n] when written 1 and leave it unchanged when written 0; when set and clear coincide, set SHALL win.
REQ-020 SHALL register irq_o = |(IRQ_STAT & IRQ_EN), one cycle after the status/enable change.
REQ-021 SHALL allow back-to-back accesses at most every second cycle, because ack gaps the transfers.

Reset
REQ-022 SHALL, while wb_rst_i is high at a clock edge, reset: OUT = 0; OEB = all 1; SEL = all 1 (core owns pads); IRQ_EN = 0; IRQ_STAT = 0; synchroniser and edge flops = 0; wbs_ack_o = 0; wbs_dat_o = 0; irq_o = 0.
REQ-023 SHALL, when reset is asserted mid-transaction, abort the access with no ack and no write; the master SHALL re-issue it.
REQ-024 SHALL, in the first cycle after reset release, suppress edge detection so reset deassertion raises no spurious IRQ.

Structure
REQ-025 SHALL place register offsets, the ID constant and the reset values in a shared package, pad_ctrl_pkg.
REQ-026 SHALL use one sub-module, pad_sync (parametrised depth, with edge output), instantiated per pad via generate.

Verification
REQ-027 SHALL cover reset: after reset, read OEB lo -> 0xFFFF_FFFF; OEB hi -> 0x0000_003F (PADS = 38); read ID -> 0x5241_5026.
REQ-028 SHALL cover pad mux: write SEL lo = 0, OUT lo = 0xA5A5_A5A5, OEB lo = 0 -> io_out[31:0] = 0xA5A5_A5A5 and io_oeb[31:0] = 0; with SEL = 1 the pad follows core_out.
REQ-029 SHALL cover byte lanes: write OUT lo = 0x1234_5678 with sel = 4'b0010 from 0 -> reads 0x0000_5600.
REQ-030 SHALL cover interrupts: IRQ_EN lo = 0x1, io_in[0] rising -> IRQ_STAT lo = 0x1 after SYNC_STAGES+1 cycles and irq_o high one cycle later; W1C 0x1 -> irq_o low.
REQ-031 SHALL cover the set/clear collision: a W1C on the same edge as a new edge -> IRQ_STAT stays 1.
REQ-032 SHALL cover unmapped access: read 0x3000_0040 and 0x3000_0100 -> one-cycle ack, data 0, no register changes.
